// File: rtl/par_to_ser_tx_if.sv
// rtl/par_to_ser_tx_if.sv - load handshake and serial output bundle for par_to_ser_tx
interface par_to_ser_tx_if #(
    parameter int word_size = 4
);
    logic [word_size-1:0] Data_in;
    logic                 load_valid;
    logic                 load_ready;
    logic                 shift_en;
    logic                 Ser_out;
    logic                 Ser_valid;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output Data_in, load_valid, shift_en,
        input  load_ready, Ser_out, Ser_valid, busy, frame_done
    );

    modport slave (
        input  Data_in, load_valid, shift_en,
        output load_ready, Ser_out, Ser_valid, busy, frame_done
    );
endinterface

// File: rtl/par_to_ser_tx.sv
// rtl/par_to_ser_tx.sv - parallel-in serial-out transmitter with one-word holding buffer
// Optional even-parity trailer bit enabled by defining PAR_TO_SER_PARITY_EN.
module par_to_ser_tx #(
    parameter int word_size = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    par_to_ser_tx_if.slave  tx
);
    localparam int CW = $clog2(word_size + 1);
`ifdef PAR_TO_SER_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(word_size);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(word_size - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [word_size-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [word_size-1:0] shifter_q, shifter_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 ser_out_q, ser_out_d;
    logic                 ser_valid_q, ser_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 head_bit;
`ifdef PAR_TO_SER_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shifter_d    = shifter_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
        parity_d     = parity_q;
`endif

        // Accept and drain are mutually exclusive: both hinge on hold_full_q.
        if (tx.load_valid && !hold_full_q) begin
            hold_d      = tx.Data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shifter_d   = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = SHIFT;
`ifdef PAR_TO_SER_PARITY_EN
                    parity_d    = ^hold_q;
`endif
                end
            end
            SHIFT: begin
                if (tx.shift_en) begin
                    if (bit_cnt_q == LAST_CNT) begin
                        frame_done_d = 1'b1;
                        bit_cnt_d    = '0;
                        if (hold_full_q) begin
                            shifter_d   = hold_q;
                            hold_full_d = 1'b0;
`ifdef PAR_TO_SER_PARITY_EN
                            parity_d    = ^hold_q;
`endif
                        end else begin
                            shifter_d = '0;
                            state_d   = IDLE;
                        end
                    end else begin
                        shifter_d = MSB_FIRST ? (shifter_q << 1) : (shifter_q >> 1);
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are computed from next state so they line up with the shifter.
        head_bit = MSB_FIRST ? shifter_d[word_size-1] : shifter_d[0];
`ifdef PAR_TO_SER_PARITY_EN
        if (bit_cnt_d == CW'(word_size)) begin
            head_bit = parity_d;
        end
`endif
        ser_valid_d = (state_d == SHIFT);
        ser_out_d   = ser_valid_d & head_bit;
        busy_d      = ser_valid_d | hold_full_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shifter_q    <= '0;
            bit_cnt_q    <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shifter_q    <= shifter_d;
            bit_cnt_q    <= bit_cnt_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef PAR_TO_SER_PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx.load_ready = ~hold_full_q;
    assign tx.Ser_out    = ser_out_q;
    assign tx.Ser_valid  = ser_valid_q;
    assign tx.busy       = busy_q;
    assign tx.frame_done = frame_done_q;
endmodule

// File: tb/tb_par_to_ser_tx.sv
// tb/tb_par_to_ser_tx.sv - directed self-checking bench for par_to_ser_tx (MSB-first and LSB-first instances)
module tb_par_to_ser_tx;
`ifdef PAR_TO_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 4 + PAR;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    par_to_ser_tx_if #(.word_size(4)) ia ();
    par_to_ser_tx_if #(.word_size(4)) ib ();

    par_to_ser_tx #(.word_size(4), .MSB_FIRST(1'b1)) dut_a (
        .clock (clock),
        .reset (reset),
        .tx    (ia.slave)
    );

    par_to_ser_tx #(.word_size(4), .MSB_FIRST(1'b0)) dut_b (
        .clock (clock),
        .reset (reset),
        .tx    (ib.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bit i of a frame carrying word w; index 4 is the parity trailer.
    function automatic logic fbit(input logic [3:0] w, input int i, input bit msb);
        if (i >= 4) return ^w;
        return msb ? w[3-i] : w[i];
    endfunction

    task automatic single(input logic [3:0] w, input string tag);
        ia.Data_in    = w;
        ia.load_valid = 1'b1;
        ia.shift_en   = 1'b1;
        tick();
        ia.load_valid = 1'b0;
        chk({tag, "_rdy_after_load"}, ia.load_ready, 0);
        chk({tag, "_busy_after_load"}, ia.busy, 1);
        chk({tag, "_valid_latency"}, ia.Ser_valid, 0);
        for (int i = 0; i < FL; i++) begin
            tick();
            chk({tag, "_valid"}, ia.Ser_valid, 1);
            chk({tag, "_bit"}, ia.Ser_out, fbit(w, i, 1'b1));
            chk({tag, "_done_early"}, ia.frame_done, 0);
        end
        tick();
        chk({tag, "_done"}, ia.frame_done, 1);
        chk({tag, "_valid_end"}, ia.Ser_valid, 0);
        chk({tag, "_out_end"}, ia.Ser_out, 0);
        tick();
        chk({tag, "_done_once"}, ia.frame_done, 0);
        chk({tag, "_busy_end"}, ia.busy, 0);
    endtask

    // Two frames back to back; bp keeps load_valid high to exercise the full holding buffer.
    task automatic pair(input logic [3:0] a, input logic [3:0] b, input bit bp, input string tag);
        ia.Data_in    = a;
        ia.load_valid = 1'b1;
        ia.shift_en   = 1'b1;
        tick();
        for (int k = 0; k < 2 * FL; k++) begin
            if (bp && k >= 2 && k <= FL) chk({tag, "_rdy_blocked"}, ia.load_ready, 0);
            if (bp) begin
                ia.load_valid = (k <= FL);
                ia.Data_in    = (k <= 1) ? b : 4'hF;
            end else begin
                ia.load_valid = (k == 1);
                ia.Data_in    = b;
            end
            tick();
            chk({tag, "_valid"}, ia.Ser_valid, 1);
            chk({tag, "_bit"}, ia.Ser_out, fbit((k < FL) ? a : b, k % FL, 1'b1));
            chk({tag, "_done"}, ia.frame_done, (k == FL) ? 1 : 0);
        end
        ia.load_valid = 1'b0;
        tick();
        chk({tag, "_done2"}, ia.frame_done, 1);
        chk({tag, "_valid_end"}, ia.Ser_valid, 0);
        tick();
        chk({tag, "_busy_end"}, ia.busy, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        ia.Data_in = '0; ia.load_valid = 1'b0; ia.shift_en = 1'b0;
        ib.Data_in = '0; ib.load_valid = 1'b0; ib.shift_en = 1'b0;
        tick();
        tick();
        chk("rst_ser_out", ia.Ser_out, 0);
        chk("rst_ser_valid", ia.Ser_valid, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_frame_done", ia.frame_done, 0);
        chk("rst_load_ready", ia.load_ready, 1);
        reset = 1'b1;
        tick();
        chk("rel_load_ready", ia.load_ready, 1);

        single(4'b1011, "single_1011");
        single(4'b0110, "single_0110");

        pair(4'b1011, 4'b0110, 1'b0, "b2b");

        pair(4'b1100, 4'b0011, 1'b1, "bp");

        // LSB-first with shift_en alternating 0,1 after the frame starts.
        ib.Data_in    = 4'b1001;
        ib.load_valid = 1'b1;
        tick();
        ib.load_valid = 1'b0;
        tick();
        chk("thr_valid0", ib.Ser_valid, 1);
        chk("thr_bit0", ib.Ser_out, fbit(4'b1001, 0, 1'b0));
        for (int j = 0; j < 2 * FL - 1; j++) begin
            ib.shift_en = (j % 2 == 1);
            tick();
            chk("thr_valid", ib.Ser_valid, 1);
            chk("thr_bit", ib.Ser_out, fbit(4'b1001, (j + 1) / 2, 1'b0));
            chk("thr_done_early", ib.frame_done, 0);
        end
        ib.shift_en = 1'b1;
        tick();
        chk("thr_done", ib.frame_done, 1);
        chk("thr_valid_end", ib.Ser_valid, 0);
        ib.shift_en = 1'b0;
        tick();
        chk("thr_done_once", ib.frame_done, 0);

        // Abort a frame after two bits with a second word waiting in the holding buffer.
        ia.Data_in    = 4'b1011;
        ia.load_valid = 1'b1;
        ia.shift_en   = 1'b1;
        tick();
        ia.load_valid = 1'b0;
        tick();
        ia.Data_in    = 4'b0110;
        ia.load_valid = 1'b1;
        tick();
        ia.load_valid = 1'b0;
        chk("abort_pre_bit1", ia.Ser_out, 0);
        chk("abort_pre_rdy", ia.load_ready, 0);
        #2 reset = 1'b0;
        #1;
        chk("abort_ser_out", ia.Ser_out, 0);
        chk("abort_ser_valid", ia.Ser_valid, 0);
        chk("abort_busy", ia.busy, 0);
        chk("abort_load_ready", ia.load_ready, 1);
        tick();
        chk("abort_no_done", ia.frame_done, 0);
        reset = 1'b1;
        tick();
        tick();
        chk("abort_hold_dropped", ia.busy, 0);
        chk("abort_no_valid", ia.Ser_valid, 0);
        chk("abort_no_done2", ia.frame_done, 0);
        single(4'b0110, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/par_to_ser_tx.md
Name: par_to_ser_tx

Overview:
Parallel-in, serial-out transmitter. It is the unload side of the team's parallel-load word register: it accepts a word_size-bit word over a valid/ready handshake and shifts the word out one bit per enabled clock. A one-word holding buffer allows a new word to be loaded while the current word shifts, so consecutive frames go out with no idle bit between them.

Parameters:
word_size, 4, data word width in bits (>=2).
MSB_FIRST, 1, bit order: 1 = bit word_size-1 goes out first; 0 = bit 0 goes out first.

Ports:
clock  input  1  rising-edge system clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Data_in  input  word_size  word to transmit.
load_valid  input  1  Data_in is valid this cycle.
load_ready  output  1  holding buffer can accept a word.
shift_en  input  1  bit-time enable; one bit advances per clock with shift_en=1.
Ser_out  output  1  current serial bit.
Ser_valid  output  1  Ser_out carries a frame bit.
busy  output  1  shifting, or holding buffer occupied.
frame_done  output  1  one-cycle pulse after a frame's last bit is consumed.

Behaviour:
- Reset (reset=0, asynchronous):
  - hold_full=0, shifter=0, bit_cnt=0, state=IDLE.
  - Ser_out=0, Ser_valid=0, busy=0, frame_done=0.
  - load_ready=1 on the first cycle after release.
- Handshake:
  - load_ready = ~hold_full (combinational).
  - A word is accepted on a rising edge with load_valid=1 and load_ready=1; Data_in is captured into the holding register and hold_full is set.
  - While hold_full=1, load_valid is ignored, even on the edge where the holding register drains (load_ready is 0 that cycle).
- States: IDLE, SHIFT.
- IDLE:
  - Ser_valid=0, Ser_out=0, shift_en ignored.
  - If hold_full=1 at an edge: hold moves to the shifter, hold_full clears, bit_cnt=0, next state SHIFT.
  - Latency: word accepted at edge N; first bit valid on Ser_out after edge N+1.
- SHIFT:
  - Ser_valid=1.
  - Ser_out = shifter MSB when MSB_FIRST=1, shifter LSB when MSB_FIRST=0.
  - Edge with shift_en=0: nothing changes; Ser_out holds.
  - Edge with shift_en=1 and bit_cnt < word_size-1: shifter shifts by one (zero fill), bit_cnt increments.
  - Edge with shift_en=1 and bit_cnt = word_size-1 (last bit):
    - frame_done=1 for exactly the following cycle.
    - If hold_full=1: reload the shifter from hold, clear hold_full, bit_cnt=0, stay in SHIFT (back-to-back, Ser_valid stays 1).
    - Else: go to IDLE, Ser_valid=0, Ser_out=0.
- busy = (state==SHIFT) | hold_full.
- bit_cnt width: clog2(word_size+1); it wraps only through the explicit reload to 0, never by overflow.
- Reset during SHIFT aborts the frame. The word in the holding register is discarded and no frame_done pulse is produced.
- All outputs except load_ready are registered.

Optional Feature:
Macro PAR_TO_SER_PARITY_EN.
- Defined: each frame gets one extra bit after the data bits, equal to the even parity (XOR reduction) of the transmitted word.
  - Frame length is word_size+1 enabled bits.
  - Ser_valid stays 1 during the parity bit.
  - frame_done pulses after the parity bit is consumed.
  - Back-to-back reload happens at the end of the parity bit.
- Undefined: no parity logic; frame is exactly word_size bits.

Test Plan:
1. Single frame: word_size=4, MSB_FIRST=1, load 4'b1011 at edge N, shift_en=1 held high -> Ser_out 1,0,1,1 on cycles N+1..N+4; Ser_valid high for exactly those 4 cycles; frame_done high only on cycle N+5; busy low after that.
2. Back-to-back: load 4'b1011 then 4'b0110 while the first word is shifting -> Ser_out 1,0,1,1,0,1,1,0 contiguously; Ser_valid never drops; frame_done pulses twice, 4 cycles apart.
3. Throttled shift: 4'b1001, MSB_FIRST=0, shift_en toggling 1,0,1,0 -> each bit held 2 cycles; sequence 1,0,0,1; frame_done one cycle after the 4th enabled edge.
4. Backpressure: hold_full=1 with the shifter busy and load_valid=1 every cycle -> load_ready=0; no overwrite of hold; hold value appears intact as the next frame.
5. Reset mid-frame: assert reset after 2 bits are out -> immediately Ser_out=0, Ser_valid=0, busy=0, load_ready=1; no frame_done pulse; a fresh load after release transmits correctly.
6. PAR_TO_SER_PARITY_EN defined: 4'b1011 -> Ser_out 1,0,1,1,1 (5 bits); 4'b0110 -> parity bit 0; frame_done after the 5th bit.
